// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: credit-limited in-order imem requests, prefetch FIFO of {pc, word},
// and redirect handling that flushes the FIFO and drops responses still in flight.
module fetch_prefetch_unit #(
   parameter int unsigned       XLEN       = 32,
   parameter logic [XLEN-1:0]   RESET_PC   = '0,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter int unsigned       MAX_OUTST  = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            fetch_fault
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FAULT = 1'b1;

   logic [0:0]      state, state_nxt;
   logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
   logic [XLEN-1:0] rsp_pc, rsp_pc_nxt;
   logic [CNT_W-1:0] outst, outst_nxt;
   logic [CNT_W-1:0] drop, drop_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic            req_valid_nxt;

   logic [31:0]     fifo_data [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];

   logic accept, keep, push, pop, misaligned;

   assign accept     = imem_req_valid & imem_req_ready;
   assign keep       = imem_rsp_valid & (drop == '0);
   assign push       = keep & ~redirect_valid;
   assign pop        = inst_valid & inst_ready & ~redirect_valid;
   assign misaligned = redirect_pc[1:0] != 2'b00;

   assign inst_valid    = count != '0;
   assign inst_data     = inst_valid ? fifo_data[rd_ptr] : '0;
   assign inst_pc       = inst_valid ? fifo_pc[rd_ptr] : '0;
   assign imem_req_addr = fetch_pc;
   assign fetch_fault   = state == ST_FAULT;

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      rsp_pc_nxt   = rsp_pc;
      drop_nxt     = drop;
      outst_nxt    = outst + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
      count_nxt    = count + CNT_W'(push) - CNT_W'(pop);

      if (accept)
         fetch_pc_nxt = fetch_pc + XLEN'(4);
      if (keep)
         rsp_pc_nxt = rsp_pc + XLEN'(4);
      if (imem_rsp_valid && drop != '0)
         drop_nxt = drop - CNT_W'(1);

      // Every request still in flight after this edge belongs to the old path.
      if (redirect_valid) begin
         state_nxt    = misaligned ? ST_FAULT : ST_RUN;
         fetch_pc_nxt = redirect_pc;
         rsp_pc_nxt   = redirect_pc;
         drop_nxt     = outst_nxt;
         count_nxt    = '0;
      end

      req_valid_nxt = (state_nxt == ST_RUN)
                   && (32'(count_nxt) + 32'(outst_nxt) < FIFO_DEPTH)
                   && (32'(outst_nxt) < MAX_OUTST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_RUN;
         fetch_pc       <= RESET_PC;
         rsp_pc         <= RESET_PC;
         outst          <= '0;
         drop           <= '0;
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         imem_req_valid <= 1'b0;
      end else begin
         state          <= state_nxt;
         fetch_pc       <= fetch_pc_nxt;
         rsp_pc         <= rsp_pc_nxt;
         outst          <= outst_nxt;
         drop           <= drop_nxt;
         count          <= count_nxt;
         imem_req_valid <= req_valid_nxt;
         if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

   // Credits reserve a slot for every kept response, so this can only trip on a logic error.
   assert property (@(posedge clk) disable iff (!reset)
                    !(push && !pop && 32'(count) == FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order, variable-latency instruction memory
// that returns addr>>2 as the instruction word.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   int          errors = 0;
   int          checks = 0;
   int          pops   = 0;
   logic [31:0] exp_pc = '0;

   int unsigned lat = 1;
   int unsigned cyc = 0;
   logic [31:0] q_data [$];
   int unsigned q_due  [$];

   always #5 clk = ~clk;

   fetch_prefetch_unit #(
      .XLEN       (32),
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (4),
      .MAX_OUTST  (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .fetch_fault    (fetch_fault)
   );

   // Memory model: sample the handshake at the edge, answer in order `lat` cycles after accept.
   always @(posedge clk) begin : mem_model
      logic        acc;
      logic [31:0] a;
      cyc = cyc + 1;
      acc = imem_req_valid & imem_req_ready;
      a   = imem_req_addr;
      if (!reset) begin
         q_data.delete();
         q_due.delete();
      end else if (acc) begin
         q_data.push_back(a >> 2);
         q_due.push_back(cyc + lat - 1);
      end
      #1;
      if (reset && q_due.size() > 0 && q_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = q_data.pop_front();
         void'(q_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge with this cycle's inputs set; checks any pop, then advances one cycle.
   task automatic tick();
      if (reset && !redirect_valid && inst_valid && inst_ready) begin
         check("inst_pc", inst_pc, exp_pc);
         check("inst_data", inst_data, exp_pc >> 2);
         exp_pc += 32'd4;
         pops++;
      end
      @(negedge clk);
   endtask

   task automatic wait_pops(input int n, input int budget);
      int start;
      start = pops;
      for (int i = 0; i < budget && (pops - start) < n; i++)
         tick();
      check("pop_count", 32'(pops - start), 32'(n));
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
      exp_pc         = target;
   endtask

   initial begin
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      repeat (2) @(negedge clk);

      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_fault", fetch_fault, 0);

      // Test 1: back-to-back delivery from reset, head first valid three edges after release.
      reset  = 1'b1;
      exp_pc = 32'h0;
      for (int i = 0; i < 7; i++) begin
         check("t1_valid", inst_valid, 32'(i >= 3));
         tick();
      end

      // Test 2: decode stall fills the FIFO and stops requests, then resumes without gaps.
      inst_ready = 1'b0;
      repeat (10) tick();
      check("t2_req_stopped", imem_req_valid, 0);
      check("t2_full_valid", inst_valid, 1);
      check("t2_head_pc", inst_pc, exp_pc);
      inst_ready = 1'b1;
      wait_pops(8, 40);

      // Test 3: slow memory keeps two requests in flight across the redirect.
      lat = 3;
      wait_pops(4, 40);
      redirect(32'h100);
      wait_pops(2, 40);

      // Test 4: redirect during a cycle with both an accept and a response.
      lat = 1;
      wait_pops(3, 20);
      redirect(32'h300);
      check("t4_req_addr", imem_req_addr, 32'h300);
      wait_pops(3, 20);

      // Test 5: misaligned target halts fetch until an aligned redirect.
      redirect(32'h102);
      for (int i = 0; i < 4; i++) begin
         check("t5_fault", fetch_fault, 1);
         check("t5_no_req", imem_req_valid, 0);
         check("t5_no_inst", inst_valid, 0);
         tick();
      end
      redirect(32'h200);
      check("t5_fault_clr", fetch_fault, 0);
      check("t5_req_valid", imem_req_valid, 1);
      wait_pops(2, 20);

      // Test 6: address wrap, then asynchronous reset in the middle of the burst.
      redirect(32'hFFFF_FFFC);
      check("t6_req_valid", imem_req_valid, 1);
      check("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      check("t6_wrap_addr", imem_req_addr, 32'h0);
      wait_pops(3, 20);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_req_valid", imem_req_valid, 0);
      check("t6_rst_req_addr", imem_req_addr, 32'h0);
      check("t6_rst_inst_valid", inst_valid, 0);
      check("t6_rst_inst_data", inst_data, 0);
      check("t6_rst_inst_pc", inst_pc, 0);
      check("t6_rst_fault", fetch_fault, 0);
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      exp_pc = 32'h0;
      tick();
      check("t6_first_req", imem_req_valid, 1);
      check("t6_first_addr", imem_req_addr, 32'h0);
      wait_pops(4, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
